// File: rtl/xdma_w_datapath.sv
// xdma_w_datapath: AXI W-channel data path for the XDMA adapter. It queues write-data
//   descriptors and streams source beats onto AXI W with first/last strobes, back-to-back bursts
//   and remote-grant gating of write-data bursts. done_o pulses once per completed burst.
// Latency: a descriptor accepted in cycle N can drive w_valid_o in cycle N+2. src->W is combinational.
// Backpressure: desc_ready_o is a registered !full. w_ready_i and grant stall the source combinationally.
// Ports: clk_i/rst_i (sync, active-high); desc_* descriptor push; src_* source beats;
//   w_* AXI W master; write_req_grant_i remote grant; done_o burst done; stats_clr_i, stat_*_o counters.
// Optional feature: define XDMA_W_DP_STATS_EN to implement the saturating statistics counters.
//   Without it the stat_*_o ports read 0 and stats_clr_i is ignored.

// Small synchronous FIFO with a registered full flag. The full flag is computed from the
// count at the end of the cycle, so a pop never frees space for a push in the same cycle.
module xdma_w_dp_fifo #(
   parameter int Width = 8,
   parameter int Depth = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [Width-1:0] i_dat,
   input  logic             i_pop,
   output logic [Width-1:0] o_dat,
   output logic             o_empty,
   output logic             o_full
);
   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(Depth);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wr_ptr;
   logic [PtrW-1:0]  r_rd_ptr;
   logic [CntW-1:0]  r_count;
   logic             r_full;
   logic [CntW-1:0]  w_count_nxt;

   always_comb begin
      w_count_nxt = r_count;
      if (i_push && !i_pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (i_pop && !i_push) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + 1'b1;
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CntFull);
      end
   end

   // Payload storage needs no reset; validity is tracked by r_count.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_dat;
      end
   end

   assign o_dat   = r_mem[r_rd_ptr];
   assign o_empty = (r_count == '0);
   assign o_full  = r_full;
endmodule

module xdma_w_datapath #(
   parameter int DataWidth  = 512,
   parameter int StrbWidth  = DataWidth / 8,
   parameter int BeatsWidth = 8,
   parameter int DescDepth  = 2,
   parameter int StatsWidth = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  desc_valid_i,
   output logic                  desc_ready_o,
   input  logic [BeatsWidth-1:0] desc_num_beats_i,
   input  logic                  desc_is_write_data_i,
   input  logic [StrbWidth-1:0]  desc_first_strb_i,
   input  logic [StrbWidth-1:0]  desc_last_strb_i,
   input  logic [DataWidth-1:0]  src_data_i,
   input  logic                  src_valid_i,
   output logic                  src_ready_o,
   output logic [DataWidth-1:0]  w_data_o,
   output logic [StrbWidth-1:0]  w_strb_o,
   output logic                  w_last_o,
   output logic                  w_valid_o,
   input  logic                  w_ready_i,
   input  logic                  write_req_grant_i,
   output logic                  done_o,
   input  logic                  stats_clr_i,
   output logic [StatsWidth-1:0] stat_beats_o,
   output logic [StatsWidth-1:0] stat_stall_o,
   output logic [StatsWidth-1:0] stat_grant_wait_o
);
   typedef struct packed {
      logic [BeatsWidth-1:0] num_beats;
      logic                  is_write_data;
      logic [StrbWidth-1:0]  first_strb;
      logic [StrbWidth-1:0]  last_strb;
   } desc_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   desc_t                 r_desc;
   logic [BeatsWidth-1:0] r_beat_cnt;
   logic                  r_first;
   logic                  r_done;

   desc_t                 w_desc_in;
   desc_t                 w_head;
   logic                  w_fifo_empty;
   logic                  w_fifo_full;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_active;
   logic                  w_gate;
   logic                  w_hs;
   logic                  w_is_last;

   assign w_desc_in = {desc_num_beats_i, desc_is_write_data_i, desc_first_strb_i, desc_last_strb_i};
   assign w_push    = desc_valid_i && !w_fifo_full;

   xdma_w_dp_fifo #(
      .Width ($bits(desc_t)),
      .Depth (DescDepth)
   ) u_desc_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_push  (w_push),
      .i_dat   (w_desc_in),
      .i_pop   (w_pop),
      .o_dat   (w_head),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

   assign desc_ready_o = !w_fifo_full;

   assign w_active  = (r_state == ST_BUSY);
   assign w_gate    = !r_desc.is_write_data || write_req_grant_i;
   assign w_is_last = (r_beat_cnt == '0);
   assign w_valid_o = w_active && src_valid_i && w_gate;
   assign src_ready_o = w_active && w_ready_i && w_gate;
   assign w_hs      = w_valid_o && w_ready_i;
   assign w_data_o  = w_active ? src_data_i : '0;
   assign w_last_o  = w_active && w_is_last;
   assign done_o    = r_done;

   always_comb begin
      w_strb_o = '0;
      if (w_active) begin
         if (r_desc.num_beats == '0) begin
            w_strb_o = r_desc.first_strb & r_desc.last_strb;
         end else if (r_first) begin
            w_strb_o = r_desc.first_strb;
         end else if (w_is_last) begin
            w_strb_o = r_desc.last_strb;
         end else begin
            w_strb_o = '1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The last-beat handshake pops the next descriptor on the same edge so bursts abut.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (w_hs && w_is_last) begin
               if (!w_fifo_empty) begin
                  w_pop = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_desc     <= '0;
         r_beat_cnt <= '0;
         r_first    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_hs && w_is_last;
         if (w_pop) begin
            r_desc     <= w_head;
            r_beat_cnt <= w_head.num_beats;
            r_first    <= 1'b1;
         end else if (w_hs) begin
            r_first <= 1'b0;
            // Holding at zero keeps the counter from wrapping after the final beat.
            if (!w_is_last) begin
               r_beat_cnt <= r_beat_cnt - 1'b1;
            end
         end
      end
   end

`ifdef XDMA_W_DP_STATS_EN
   logic [StatsWidth-1:0] r_stat_beats;
   logic [StatsWidth-1:0] r_stat_stall;
   logic [StatsWidth-1:0] r_stat_grant_wait;
   logic                  w_inc_stall;
   logic                  w_inc_grant_wait;

   assign w_inc_stall      = w_valid_o && !w_ready_i;
   assign w_inc_grant_wait = w_active && r_desc.is_write_data && src_valid_i && !write_req_grant_i;

   // Counters saturate at all ones; a clear wins over a same-cycle increment.
   always_ff @(posedge clk_i) begin
      if (rst_i || stats_clr_i) begin
         r_stat_beats      <= '0;
         r_stat_stall      <= '0;
         r_stat_grant_wait <= '0;
      end else begin
         if (w_hs && !(&r_stat_beats)) begin
            r_stat_beats <= r_stat_beats + 1'b1;
         end
         if (w_inc_stall && !(&r_stat_stall)) begin
            r_stat_stall <= r_stat_stall + 1'b1;
         end
         if (w_inc_grant_wait && !(&r_stat_grant_wait)) begin
            r_stat_grant_wait <= r_stat_grant_wait + 1'b1;
         end
      end
   end

   assign stat_beats_o      = r_stat_beats;
   assign stat_stall_o      = r_stat_stall;
   assign stat_grant_wait_o = r_stat_grant_wait;
`else
   logic w_unused_stats_clr;
   assign w_unused_stats_clr = stats_clr_i;
   assign stat_beats_o       = '0;
   assign stat_stall_o       = '0;
   assign stat_grant_wait_o  = '0;
`endif
endmodule

// File: doc/xdma_w_datapath.md
# xdma_w_datapath

Parametrised AXI W-channel data path for the XDMA adapter. It queues write-data descriptors and streams source beats onto the AXI W channel. Bursts run back-to-back with no idle cycles between them. Each burst carries first-beat and last-beat byte strobes, and write-data bursts are gated on the remote grant. It sits between the XDMA descriptor/config logic (descriptor and source streams) and the AXI master W port, and reports each completed burst with a done pulse.

## Interface
- DataWidth, 512: AXI W data width in bits; must be a multiple of 8.
- StrbWidth, DataWidth/8: strobe width (derived, do not override).
- BeatsWidth, 8: width of the burst length field (AXI len, beats minus one).
- DescDepth, 2: descriptor FIFO entries; power of two, ≥1.
- StatsWidth, 32: width of each statistics counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- desc_valid_i  in  1  descriptor valid.
- desc_ready_o  out  1  descriptor FIFO not full.
- desc_num_beats_i  in  BeatsWidth  burst length minus one.
- desc_is_write_data_i  in  1  burst is remote write data and requires grant.
- desc_first_strb_i  in  StrbWidth  strobe for the first beat.
- desc_last_strb_i  in  StrbWidth  strobe for the last beat.
- src_data_i  in  DataWidth  source beat data.
- src_valid_i  in  1  source beat valid.
- src_ready_o  out  1  source beat consumed.
- w_data_o  out  DataWidth  AXI W data.
- w_strb_o  out  StrbWidth  AXI W strobe.
- w_last_o  out  1  AXI W last.
- w_valid_o  out  1  AXI W valid.
- w_ready_i  in  1  AXI W ready.
- write_req_grant_i  in  1  remote grant for write-data bursts.
- done_o  out  1  one-cycle pulse per completed burst.
- stats_clr_i  in  1  clear the statistics counters.
- stat_beats_o  out  StatsWidth  W beats transferred.
- stat_stall_o  out  StatsWidth  cycles with w_valid_o=1 and w_ready_i=0.
- stat_grant_wait_o  out  StatsWidth  cycles the active write-data burst has src_valid_i=1 but write_req_grant_i=0.

## Operation
- Descriptor FIFO: push on desc_valid_i && desc_ready_o.
  - desc_ready_o = !full, registered. It takes no credit from a same-cycle pop.
- Active-burst registers hold the head descriptor, beat_cnt (remaining beats minus one), first_q and active_q.
- State machine with two states, IDLE (active_q=0) and BUSY (active_q=1):
  - IDLE → BUSY when the FIFO is non-empty: pop the head, load beat_cnt=num_beats, set first_q=1.
  - BUSY, last-beat handshake, FIFO non-empty → stay in BUSY and load the next descriptor on the same edge (zero bubble).
  - BUSY, last-beat handshake, FIFO empty → IDLE.
- gate = !is_write_data || write_req_grant_i.
- w_valid_o = active_q && src_valid_i && gate.
- src_ready_o = active_q && w_ready_i && gate.
- w_data_o = src_data_i when active_q, else 0.
- w_last_o = active_q && beat_cnt==0.
- w_strb_o selection:
  - single beat (num_beats==0): first_strb & last_strb.
  - first beat: first_strb.
  - last beat: last_strb.
  - any other beat: all ones.
  - not active: 0.
- On each handshake (w_valid_o && w_ready_i): beat_cnt decrements and first_q clears.
- done_o is registered: high for exactly one cycle after each last-beat handshake.
- Widths: beat_cnt is BeatsWidth wide and never wraps below 0. num_beats=2^BeatsWidth−1 gives 2^BeatsWidth beats.

## Timing
- Reset values:
  - All outputs 0 except desc_ready_o=1.
  - FIFO empty, active_q=0, counters 0.
- Reset mid-burst aborts the burst with no done_o. Queued descriptors are discarded.
- Descriptor-to-W latency: a descriptor accepted in cycle N can first drive w_valid_o in cycle N+2.
- Push into an empty FIFO is not popped in the same cycle.
- Grant deasserting mid-burst stalls immediately: w_valid_o and src_ready_o drop in that cycle, and beat_cnt holds.
- Full FIFO plus a same-cycle pop: desc_ready_o stays 0 for that cycle and rises the next cycle.
- No combinational path from desc_valid_i to any output.
- Combinational paths w_ready_i→src_ready_o and src_valid_i→w_valid_o are intentional.

## Configuration
- XDMA_W_DP_STATS_EN defined:
  - The three statistics counters are implemented and saturate at all ones.
  - stats_clr_i zeroes all three counters on the next edge and takes priority over increments.
- XDMA_W_DP_STATS_EN undefined:
  - No counter flops.
  - stat_*_o tied to 0 and stats_clr_i ignored.
  - Ports remain present.

## Test plan
- Single beat: num_beats=0, first_strb=0x0F..F0, last_strb=0xFF..0F, w_ready_i=1, valid source → one beat with w_strb_o = first&last, w_last_o=1, done_o pulse one cycle later.
- Back-to-back: two descriptors num_beats=3 and 1, w_ready_i held 1 → six consecutive beats with w_valid_o high every cycle and w_last_o on beats 4 and 6; two done_o pulses.
- Grant gating: is_write_data=1, num_beats=7, grant low for 5 cycles mid-burst → no beats during the gap, stat_grant_wait_o=5, 8 beats total.
- Backpressure: w_ready_i toggling 1/0 over a 16-beat burst → stat_stall_o equals the number of stall cycles, and data order is preserved.
- FIFO full: DescDepth=2, push 3 descriptors while w_ready_i=0 → desc_ready_o=0 after the FIFO holds 2 with 1 active; it reasserts on the cycle after the first done.
- Reset mid-burst: rst_i high during beat 3 of 8 → all valids 0 next cycle, no done_o, desc_ready_o=1; a new descriptor runs a clean full burst afterwards.
